// File: rtl/mine_pkg.sv
// Shared types and helpers for the minesweeper board controller.
// nb_valid is the single edge-clipping rule used by both mine counting and flood sweep.
package mine_pkg;

  localparam int N = 8;
  localparam logic [3:0] MINE = 4'hf;

  typedef enum logic [3:0] {
    HIDDEN = 4'd0,
    SHOWN  = 4'd1,
    FLAG   = 4'd2
  } cell_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    SWEEP,
    LOST,
    WON
  } state_t;

  // True when (i+di, j+dj) is a real neighbour on the board (centre excluded).
  function automatic logic nb_valid(input logic [2:0] i, input logic [2:0] j,
                                    input int di, input int dj);
    int ni;
    int nj;
    ni = int'(i) + di;
    nj = int'(j) + dj;
    return !(di == 0 && dj == 0) && ni >= 0 && ni < N && nj >= 0 && nj < N;
  endfunction

endpackage

// File: rtl/nb_count.sv
// Combinational count of mines among the 8 neighbours of cell (i, j),
// clipped at the board edges.
module nb_count
  import mine_pkg::*;
(
  input  logic [7:0][7:0] mine_map,
  input  logic [2:0]      i,
  input  logic [2:0]      j,
  output logic [3:0]      count
);

  always_comb begin
    count = 4'd0;
    for (int di = -1; di <= 1; di++) begin
      for (int dj = -1; dj <= 1; dj++) begin
        if (nb_valid(i, j, di, dj)) begin
          count = count + {3'd0, mine_map[i + 3'(di)][j + 3'(dj)]};
        end
      end
    end
  end

endmodule

// File: rtl/board_ctrl.sv
// Minesweeper board controller: loads the mine map into per-cell numbers,
// then handles cursor, flag and reveal actions with an iterative flood sweep.
module board_ctrl
  import mine_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0][7:0]       mine_map,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_reveal,
  input  logic                  btn_flag,
  input  logic                  btn_start,
  output logic [2:0]            pos_x,
  output logic [2:0]            pos_y,
  output logic [7:0][7:0][3:0]  mNum,
  output logic [7:0][7:0][3:0]  mJ,
  output logic                  game_over,
  output logic                  game_won
);

  state_t               state_q, state_d;
  logic [2:0]           pos_x_q, pos_x_d;
  logic [2:0]           pos_y_q, pos_y_d;
  logic [7:0][7:0][3:0] mnum_q, mnum_d;
  logic [7:0][7:0][3:0] mj_q, mj_d;
  logic [6:0]           mine_cnt_q, mine_cnt_d;
  logic [6:0]           rev_cnt_q, rev_cnt_d;
  logic [5:0]           k_q, k_d;
  logic                 swept_q, swept_d;

  logic [2:0] ci, cj;
  logic [3:0] load_cnt;
  logic       sweep_hit;
  logic       cell_hit;
  logic       board_clear;

  assign ci          = k_q[5:3];
  assign cj          = k_q[2:0];
  assign board_clear = (rev_cnt_q == 7'd64 - mine_cnt_q);

  nb_count u_nb_count (
    .mine_map (mine_map),
    .i        (ci),
    .j        (cj),
    .count    (load_cnt)
  );

  // Sweep trigger: some in-board neighbour is already revealed with a zero count.
  always_comb begin
    sweep_hit = 1'b0;
    for (int di = -1; di <= 1; di++) begin
      for (int dj = -1; dj <= 1; dj++) begin
        if (nb_valid(ci, cj, di, dj) &&
            mj_q[ci + 3'(di)][cj + 3'(dj)] == SHOWN &&
            mnum_q[ci + 3'(di)][cj + 3'(dj)] == 4'd0) begin
          sweep_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    mnum_d     = mnum_q;
    mj_d       = mj_q;
    mine_cnt_d = mine_cnt_q;
    rev_cnt_d  = rev_cnt_q;
    k_d        = k_q;
    swept_d    = swept_q;
    cell_hit   = 1'b0;

    if (btn_start) begin
      mj_d       = '0;
      mine_cnt_d = 7'd0;
      rev_cnt_d  = 7'd0;
      k_d        = 6'd0;
      swept_d    = 1'b0;
      state_d    = LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          mnum_d[ci][cj] = mine_map[ci][cj] ? MINE : load_cnt;
          if (mine_map[ci][cj]) begin
            mine_cnt_d = mine_cnt_q + 7'd1;
          end
          k_d = k_q + 6'd1;
          if (k_q == 6'd63) begin
            rev_cnt_d = 7'd0;
            state_d   = PLAY;
          end
        end

        PLAY: begin
          if (board_clear) begin
            state_d = WON;
          end else if (btn_reveal) begin
            if (mj_q[pos_x_q][pos_y_q] == HIDDEN) begin
              if (mnum_q[pos_x_q][pos_y_q] == MINE) begin
                for (int a = 0; a < N; a++) begin
                  for (int b = 0; b < N; b++) begin
                    if (mnum_q[3'(a)][3'(b)] == MINE) begin
                      mj_d[3'(a)][3'(b)] = SHOWN;
                    end
                  end
                end
                state_d = LOST;
              end else begin
                mj_d[pos_x_q][pos_y_q] = SHOWN;
                rev_cnt_d = rev_cnt_q + 7'd1;
                if (mnum_q[pos_x_q][pos_y_q] == 4'd0) begin
                  k_d     = 6'd0;
                  swept_d = 1'b0;
                  state_d = SWEEP;
                end
              end
            end
          end else if (btn_flag) begin
            if (mj_q[pos_x_q][pos_y_q] == HIDDEN) begin
              mj_d[pos_x_q][pos_y_q] = FLAG;
            end else if (mj_q[pos_x_q][pos_y_q] == FLAG) begin
              mj_d[pos_x_q][pos_y_q] = HIDDEN;
            end
          end else if (btn_up) begin
            pos_y_d = pos_y_q - 3'd1;
          end else if (btn_down) begin
            pos_y_d = pos_y_q + 3'd1;
          end else if (btn_left) begin
            pos_x_d = pos_x_q - 3'd1;
          end else if (btn_right) begin
            pos_x_d = pos_x_q + 3'd1;
          end
        end

        // Flagged cells are not hidden, so the flood leaves them alone.
        SWEEP: begin
          cell_hit = (mj_q[ci][cj] == HIDDEN) && (mnum_q[ci][cj] != MINE) && sweep_hit;
          if (cell_hit) begin
            mj_d[ci][cj] = SHOWN;
            rev_cnt_d    = rev_cnt_q + 7'd1;
            swept_d      = 1'b1;
          end
          k_d = k_q + 6'd1;
          if (k_q == 6'd63) begin
            swept_d = 1'b0;
            if (!(swept_q || cell_hit)) begin
              state_d = board_clear ? WON : PLAY;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pos_x_q    <= 3'd0;
      pos_y_q    <= 3'd0;
      mnum_q     <= '0;
      mj_q       <= '0;
      mine_cnt_q <= 7'd0;
      rev_cnt_q  <= 7'd0;
      k_q        <= 6'd0;
      swept_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      mnum_q     <= mnum_d;
      mj_q       <= mj_d;
      mine_cnt_q <= mine_cnt_d;
      rev_cnt_q  <= rev_cnt_d;
      k_q        <= k_d;
      swept_q    <= swept_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign mNum      = mnum_q;
  assign mJ        = mj_q;
  assign game_over = (state_q == LOST);
  assign game_won  = (state_q == WON);

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: a table of PLAY-mode button vectors plus
// hand-written load, lose, flood, win and reset sequences.
module tb_board_ctrl;
  import mine_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [7:0][7:0]      mine_map;
  logic                 btn_up, btn_down, btn_left, btn_right;
  logic                 btn_reveal, btn_flag, btn_start;
  logic [2:0]           pos_x, pos_y;
  logic [7:0][7:0][3:0] mNum, mJ;
  logic                 game_over, game_won;

  int n_cmp;
  int n_fail;

  localparam logic [6:0] B_START  = 7'b1000000;
  localparam logic [6:0] B_REVEAL = 7'b0100000;
  localparam logic [6:0] B_FLAG   = 7'b0010000;
  localparam logic [6:0] B_UP     = 7'b0001000;
  localparam logic [6:0] B_DOWN   = 7'b0000100;
  localparam logic [6:0] B_LEFT   = 7'b0000010;
  localparam logic [6:0] B_RIGHT  = 7'b0000001;

  typedef struct {
    logic [6:0] btns;
    logic [2:0] exp_x;
    logic [2:0] exp_y;
    logic [3:0] exp_cell;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  board_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mine_map   (mine_map),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_reveal (btn_reveal),
    .btn_flag   (btn_flag),
    .btn_start  (btn_start),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .mNum       (mNum),
    .mJ         (mJ),
    .game_over  (game_over),
    .game_won   (game_won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one button pulse for exactly one rising edge; returns 1 time unit after it.
  task automatic applyStimulus(input logic [6:0] b);
    @(negedge clk);
    {btn_start, btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = b;
    @(posedge clk);
    #1;
    {btn_start, btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = 7'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " state"}, 32'(dut.state_q), 32'(IDLE));
    checkOutput({tag, " pos_x"}, 32'(pos_x), 32'd0);
    checkOutput({tag, " pos_y"}, 32'(pos_y), 32'd0);
    checkOutput({tag, " mJ_zero"}, 32'(mJ === '0), 32'd1);
    checkOutput({tag, " mNum_zero"}, 32'(mNum === '0), 32'd1);
    checkOutput({tag, " game_over"}, 32'(game_over), 32'd0);
    checkOutput({tag, " game_won"}, 32'(game_won), 32'd0);
    checkOutput({tag, " mine_cnt"}, 32'(dut.mine_cnt_q), 32'd0);
    checkOutput({tag, " rev_cnt"}, 32'(dut.rev_cnt_q), 32'd0);
  endtask

  initial begin
    int guard;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    mine_map = '0;
    {btn_start, btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = 7'b0;

    vecs[0]  = '{B_LEFT,            3'd7, 3'd0, 4'd0};
    vecs[1]  = '{B_UP,              3'd7, 3'd7, 4'd0};
    vecs[2]  = '{B_RIGHT,           3'd0, 3'd7, 4'd0};
    vecs[3]  = '{B_DOWN,            3'd0, 3'd0, 4'd0};
    vecs[4]  = '{B_RIGHT,           3'd1, 3'd0, 4'd0};
    vecs[5]  = '{B_RIGHT | B_LEFT,  3'd0, 3'd0, 4'd0};
    vecs[6]  = '{B_RIGHT,           3'd1, 3'd0, 4'd0};
    vecs[7]  = '{B_RIGHT,           3'd2, 3'd0, 4'd0};
    vecs[8]  = '{B_DOWN,            3'd2, 3'd1, 4'd0};
    vecs[9]  = '{B_DOWN | B_UP,     3'd2, 3'd0, 4'd0};
    vecs[10] = '{B_DOWN,            3'd2, 3'd1, 4'd0};
    vecs[11] = '{B_DOWN,            3'd2, 3'd2, 4'd0};
    vecs[12] = '{B_REVEAL | B_RIGHT, 3'd2, 3'd2, 4'd1};
    vecs[13] = '{B_FLAG,            3'd2, 3'd2, 4'd1};
    vecs[14] = '{B_REVEAL,          3'd2, 3'd2, 4'd1};
    vecs[15] = '{B_RIGHT,           3'd3, 3'd2, 4'd0};
    vecs[16] = '{B_DOWN,            3'd3, 3'd3, 4'd0};
    vecs[17] = '{B_FLAG | B_LEFT,   3'd3, 3'd3, 4'd2};
    vecs[18] = '{B_REVEAL,          3'd3, 3'd3, 4'd2};
    vecs[19] = '{B_FLAG,            3'd3, 3'd3, 4'd0};
    vecs[20] = '{B_FLAG,            3'd3, 3'd3, 4'd2};
    vecs[21] = '{B_FLAG | B_DOWN,   3'd3, 3'd3, 4'd0};

    // Reset state and IDLE ignoring non-start buttons
    waitCycles(2);
    rst = 1'b0;
    checkResetState("reset");
    applyStimulus(B_RIGHT | B_REVEAL | B_FLAG);
    checkOutput("idle pos_x", 32'(pos_x), 32'd0);
    checkOutput("idle mJ_zero", 32'(mJ === '0), 32'd1);
    checkOutput("idle state", 32'(dut.state_q), 32'(IDLE));

    // Single mine at (3,3): LOAD lasts exactly 64 cycles
    mine_map[3][3] = 1'b1;
    applyStimulus(B_START);
    checkOutput("start state", 32'(dut.state_q), 32'(LOAD));
    waitCycles(63);
    checkOutput("load63 state", 32'(dut.state_q), 32'(LOAD));
    waitCycles(1);
    checkOutput("load64 state", 32'(dut.state_q), 32'(PLAY));
    checkOutput("mNum[2][2]", 32'(mNum[2][2]), 32'd1);
    checkOutput("mNum[3][3]", 32'(mNum[3][3]), 32'd15);
    checkOutput("mNum[0][0]", 32'(mNum[0][0]), 32'd0);
    checkOutput("mNum[4][4]", 32'(mNum[4][4]), 32'd1);
    checkOutput("mNum[2][4]", 32'(mNum[2][4]), 32'd1);
    checkOutput("mNum[5][5]", 32'(mNum[5][5]), 32'd0);
    checkOutput("mine_cnt 1", 32'(dut.mine_cnt_q), 32'd1);
    checkOutput("rev_cnt 0", 32'(dut.rev_cnt_q), 32'd0);

    // Table of PLAY-mode vectors
    for (int r = 0; r < NVEC; r++) begin
      applyStimulus(vecs[r].btns);
      checkOutput($sformatf("vec%0d pos_x", r), 32'(pos_x), 32'(vecs[r].exp_x));
      checkOutput($sformatf("vec%0d pos_y", r), 32'(pos_y), 32'(vecs[r].exp_y));
      checkOutput($sformatf("vec%0d cell", r), 32'(mJ[vecs[r].exp_x][vecs[r].exp_y]),
                  32'(vecs[r].exp_cell));
      checkOutput($sformatf("vec%0d state", r), 32'(dut.state_q), 32'(PLAY));
    end
    checkOutput("rev_cnt after table", 32'(dut.rev_cnt_q), 32'd1);

    // Reveal the mine at (3,3), then buttons are dead until start
    applyStimulus(B_REVEAL);
    checkOutput("lose mJ[3][3]", 32'(mJ[3][3]), 32'd1);
    checkOutput("lose game_over", 32'(game_over), 32'd1);
    checkOutput("lose game_won", 32'(game_won), 32'd0);
    checkOutput("lose mJ[0][0]", 32'(mJ[0][0]), 32'd0);
    applyStimulus(B_RIGHT);
    applyStimulus(B_FLAG | B_UP);
    checkOutput("lost pos_x", 32'(pos_x), 32'd3);
    checkOutput("lost pos_y", 32'(pos_y), 32'd3);
    checkOutput("lost mJ[2][2]", 32'(mJ[2][2]), 32'd1);
    checkOutput("lost game_over", 32'(game_over), 32'd1);
    applyStimulus(B_START);
    checkOutput("restart state", 32'(dut.state_q), 32'(LOAD));
    checkOutput("restart mJ_zero", 32'(mJ === '0), 32'd1);
    checkOutput("restart game_over", 32'(game_over), 32'd0);
    applyStimulus(B_RIGHT);
    checkOutput("load ignores right", 32'(pos_x), 32'd3);
    waitCycles(62);
    checkOutput("reload63 state", 32'(dut.state_q), 32'(LOAD));
    waitCycles(1);
    checkOutput("reload state", 32'(dut.state_q), 32'(PLAY));
    checkOutput("reload mine_cnt", 32'(dut.mine_cnt_q), 32'd1);

    // Mines in column 7: flood from (0,0) ends in WON after two passes
    doReset();
    checkResetState("reset2");
    mine_map = '0;
    mine_map[7] = 8'hff;
    applyStimulus(B_START);
    waitCycles(64);
    checkOutput("col7 state", 32'(dut.state_q), 32'(PLAY));
    checkOutput("col7 mine_cnt", 32'(dut.mine_cnt_q), 32'd8);
    checkOutput("col7 mNum[6][0]", 32'(mNum[6][0]), 32'd2);
    checkOutput("col7 mNum[6][3]", 32'(mNum[6][3]), 32'd3);
    checkOutput("col7 mNum[7][0]", 32'(mNum[7][0]), 32'd15);
    applyStimulus(B_REVEAL);
    checkOutput("col7 sweep state", 32'(dut.state_q), 32'(SWEEP));
    checkOutput("col7 sweep rev", 32'(dut.rev_cnt_q), 32'd1);
    waitCycles(127);
    checkOutput("col7 pass2 state", 32'(dut.state_q), 32'(SWEEP));
    waitCycles(1);
    checkOutput("col7 won state", 32'(dut.state_q), 32'(WON));
    checkOutput("col7 game_won", 32'(game_won), 32'd1);
    checkOutput("col7 game_over", 32'(game_over), 32'd0);
    checkOutput("col7 rev_cnt", 32'(dut.rev_cnt_q), 32'd56);
    checkOutput("col7 mJ[6][0]", 32'(mJ[6][0]), 32'd1);
    checkOutput("col7 mJ[6][7]", 32'(mJ[6][7]), 32'd1);
    checkOutput("col7 mJ[5][4]", 32'(mJ[5][4]), 32'd1);
    checkOutput("col7 mJ[7][2]", 32'(mJ[7][2]), 32'd0);
    applyStimulus(B_LEFT);
    checkOutput("won ignores left", 32'(pos_x), 32'd0);

    // Reset mid-sweep (pass 1, k=20), with start in the same cycle
    applyStimulus(B_START);
    waitCycles(64);
    applyStimulus(B_REVEAL);
    waitCycles(20);
    checkOutput("midsweep state", 32'(dut.state_q), 32'(SWEEP));
    checkOutput("midsweep k", 32'(dut.k_q), 32'd20);
    @(negedge clk);
    rst = 1'b1;
    btn_start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    btn_start = 1'b0;
    checkResetState("sweep_rst");
    waitCycles(1);
    checkOutput("sweep_rst stays idle", 32'(dut.state_q), 32'(IDLE));

    // Zero mines: a single reveal floods the board
    mine_map = '0;
    applyStimulus(B_START);
    waitCycles(64);
    checkOutput("empty mine_cnt", 32'(dut.mine_cnt_q), 32'd0);
    applyStimulus(B_REVEAL);
    checkOutput("empty sweep state", 32'(dut.state_q), 32'(SWEEP));
    guard = 0;
    while (dut.state_q == SWEEP && guard < 400) begin
      waitCycles(1);
      guard++;
    end
    checkOutput("empty sweep bounded", 32'(guard < 400), 32'd1);
    checkOutput("empty sweep cycles", 32'(guard), 32'd128);
    checkOutput("empty won state", 32'(dut.state_q), 32'(WON));
    checkOutput("empty rev_cnt", 32'(dut.rev_cnt_q), 32'd64);
    checkOutput("empty mJ[7][7]", 32'(mJ[7][7]), 32'd1);
    checkOutput("empty game_won", 32'(game_won), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/board_ctrl.md
BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 rst  in  1  synchronous reset, active-high.
REQ-003 mine_map  in  [7:0][7:0]  mine mask indexed [i][j] (i column, j row); 1 = mine; sampled only during LOAD.
REQ-004 btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag, btn_start  in  1 each  single-cycle debounced pulses.
REQ-005 pos_x, pos_y  out  3 each  cursor column and row.
REQ-006 mNum  out  [7:0][7:0][3:0]  per-cell value: 4'hf = mine, otherwise neighbour-mine count 0..8.
REQ-007 mJ  out  [7:0][7:0][3:0]  per-cell state: 0 hidden, 1 revealed, 2 flagged; no other value is ever driven.
REQ-008 game_over, game_won  out  1 each  level flags for states LOST and WON.

Function
REQ-009 The FSM states SHALL be IDLE, LOAD, PLAY, SWEEP, LOST and WON.
REQ-010 btn_start in any state SHALL clear all mJ to 0, clear the mine counter and enter LOAD on the next cycle.
REQ-011 LOAD SHALL take exactly 64 cycles; on cycle k it processes cell i=k[5:3], j=k[2:0].
REQ-012 For each cell in LOAD: write mNum = 4'hf if mine_map[i][j]=1, otherwise the count of set 8-neighbours, clipped at the board edges; a mine increments mine_cnt (7 bits).
REQ-013 After cycle 63, LOAD SHALL enter PLAY; the revealed counter rev_cnt (7 bits) is 0 at that point.
REQ-014 In PLAY, at most one action SHALL be taken per cycle, in priority order: start > reveal > flag > up > down > left > right.
REQ-015 Cursor moves SHALL wrap: left from pos_x=0 gives 7, right from 7 gives 0; up and down wrap pos_y the same way.
REQ-016 Reveal on a flagged or already revealed cell SHALL be ignored.
REQ-017 Reveal on a hidden mine SHALL set mJ=1 on every mine cell and enter LOST.
REQ-018 Reveal on a hidden non-mine cell SHALL set mJ=1 and increment rev_cnt; if its mNum is 0, the FSM SHALL enter SWEEP, otherwise it stays in PLAY.
REQ-019 Flag SHALL toggle mJ 0<->2 and SHALL be ignored on revealed cells.
REQ-020 SWEEP SHALL make passes of 64 cycles in index order k=0..63 and process one cell per cycle.
REQ-021 In a pass, a cell SHALL be revealed (mJ=1, rev_cnt+1) if it is hidden, not a mine, and has any 8-neighbour with mJ=1 and mNum=0.
REQ-022 Updates in a pass SHALL take effect immediately and are visible to later cells in the same pass.
REQ-023 A pass with at least one reveal SHALL be followed by another pass; a pass with no reveal SHALL return to PLAY.
REQ-024 Button pulses during SWEEP, LOAD, LOST and WON SHALL be ignored, except btn_start.
REQ-025 Whenever rev_cnt = 64 - mine_cnt in PLAY, or at the end of SWEEP, the FSM SHALL enter WON.
REQ-026 Zero mines: the first reveal floods the whole board and the FSM ends in WON.
REQ-027 game_over=1 exactly in LOST; game_won=1 exactly in WON.
REQ-028 IDLE SHALL ignore every button except start.

Reset
REQ-029 rst SHALL set mJ=0, mNum=0, pos_x=pos_y=0, mine_cnt=rev_cnt=0, game_over=game_won=0 and state IDLE.
REQ-030 rst SHALL take priority over btn_start in the same cycle.
REQ-031 rst SHALL abort LOAD or SWEEP mid-pass with no residual state.

Structure
REQ-032 Shared package mine_pkg SHALL hold: N=8, MINE=4'hf, the cell-state enum (HIDDEN=0, SHOWN=1, FLAG=2), and the FSM state enum.
REQ-033 The 8-neighbour mine count SHALL be a combinational sub-module nb_count: inputs mine_map, i, j; output a 4-bit count.
REQ-034 The SWEEP neighbour test SHALL share the same edge-clipping rule as nb_count.

Verification
REQ-035 Single mine at (3,3), start -> after 64 cycles PLAY; mNum[2][2]=1, mNum[3][3]=4'hf, mNum[0][0]=0, mine_cnt=1.
REQ-036 Cursor at (0,0): left then up -> pos=(7,7); btn_reveal and btn_right in the same cycle -> only reveal is taken and pos is unchanged.
REQ-037 Mines only in column 7: reveal (0,0) -> SWEEP; columns 0..5 become revealed, and column 6 is revealed with mNum 2 or 3; then WON with rev_cnt=56.
REQ-038 Flag (3,3), reveal (3,3) -> mJ[3][3] stays 2; flag again -> 0.
REQ-039 Reveal the mine at (3,3) -> mJ[3][3]=1, game_over=1; later button presses have no effect; btn_start -> LOAD, all mJ=0.
REQ-040 Assert rst for 1 cycle mid-SWEEP (pass 1, k=20) -> the next cycle shows IDLE with all outputs at reset values.
